// File: rtl/ooo_types_pkg.sv
// ============================================================================
// Module      : ooo_types (package)
// Description : Shared types for the out-of-order core: renamed instruction
//               record, functional-unit encoding, register/ROB widths, and
//               the dispatch buffer entry layout.
// Revision    : 1.1 - NUM_PHYS_REGS, dispatch entry and routing helper added
// ============================================================================
`default_nettype none

package ooo_types;

    localparam int NUM_ARCH_REGS = 32;
    localparam int PHYS_REG_BITS = 7;
    localparam int NUM_PHYS_REGS = 2 ** PHYS_REG_BITS;
    localparam int ROB_BITS      = 5;
    localparam int CKPT_MAP_BITS = NUM_ARCH_REGS * PHYS_REG_BITS;

    // Functional-unit class carried by each renamed instruction. Encoding 3
    // is unassigned and is treated as an ALU operation downstream.
    typedef enum logic [1:0] {
        FU_ALU    = 2'd0,
        FU_MEM    = 2'd1,
        FU_BRANCH = 2'd2
    } fu_type_t;

    typedef struct packed {
        logic [31:0]              pc;
        fu_type_t                 fu_type;
        logic                     is_branch;
        logic                     reg_write;
        logic [PHYS_REG_BITS-1:0] prd;
        logic [PHYS_REG_BITS-1:0] prs1;
        logic [PHYS_REG_BITS-1:0] prs2;
        logic [ROB_BITS-1:0]      rob_tag;
    } renamed_instr_t;

    // Reservation station selected for the instruction at the dispatch head.
    typedef enum logic [1:0] {
        TGT_ALU = 2'd0,
        TGT_LSU = 2'd1,
        TGT_BR  = 2'd2
    } rs_tgt_t;

    // One dispatch buffer slot: the instruction plus its branch checkpoint.
    typedef struct packed {
        logic [CKPT_MAP_BITS-1:0] ckpt_map;
        logic [PHYS_REG_BITS-1:0] ckpt_fl_ptr;
        logic [ROB_BITS-1:0]      ckpt_rob_tag;
        renamed_instr_t           instr;
    } dispatch_entry_t;

    // Map a functional-unit class onto a reservation station; anything that
    // is not memory or branch goes to the ALU station.
    function automatic rs_tgt_t route_fu(input fu_type_t fu);
        rs_tgt_t tgt;
        case (fu)
            FU_MEM:    tgt = TGT_LSU;
            FU_BRANCH: tgt = TGT_BR;
            default:   tgt = TGT_ALU;
        endcase
        return tgt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dispatch_skid_buf.sv
// ============================================================================
// Module      : dispatch_skid_buf
// Description : Two-entry FIFO with a ready that depends only on its own
//               occupancy, decoupling rename from downstream backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dispatch_skid_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    // The 1-bit pointers below only address two slots.
    if (DEPTH != 2) begin : g_depth_check
        $error("dispatch_skid_buf supports DEPTH == 2 only");
    end

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q,  count_d;
    logic             w_push;
    logic             w_pop;

    // Ready and valid come straight from the occupancy register, so no
    // downstream ready can reach the upstream handshake combinationally.
    assign ready_o = (count_q != 2'd2);
    assign valid_o = (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];

    // A flush swallows both the pop and any push arriving in the same cycle.
    assign w_push = push_i && ready_o && !flush_i;
    assign w_pop  = pop_i  && valid_o && !flush_i;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (w_push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; a slot is only written on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dispatch.sv
// ============================================================================
// Module      : dispatch
// Description : Post-rename dispatch stage. Buffers renamed instructions,
//               allocates them into the ROB, routes them to the ALU, LSU or
//               branch reservation station, and maintains the physical
//               register ready table that feeds operand-ready bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dispatch
    import ooo_types::*;
#(
    parameter int NUM_PHYS_REGS = ooo_types::NUM_PHYS_REGS,
    parameter int BUF_DEPTH     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,

    // From rename
    input  logic                     in_valid,
    output logic                     in_ready,
    input  renamed_instr_t           in_instr,
    input  logic [CKPT_MAP_BITS-1:0] in_ckpt_map,
    input  logic [PHYS_REG_BITS-1:0] in_ckpt_fl_ptr,
    input  logic [ROB_BITS-1:0]      in_ckpt_rob_tag,

    // ROB allocation
    output logic                     rob_valid,
    input  logic                     rob_ready,
    output renamed_instr_t           rob_instr,
    output logic [CKPT_MAP_BITS-1:0] rob_ckpt_map,
    output logic [PHYS_REG_BITS-1:0] rob_ckpt_fl_ptr,
    output logic [ROB_BITS-1:0]      rob_ckpt_rob_tag,

    // Reservation stations
    output logic                     alu_rs_valid,
    input  logic                     alu_rs_ready,
    output logic                     lsu_rs_valid,
    input  logic                     lsu_rs_ready,
    output logic                     br_rs_valid,
    input  logic                     br_rs_ready,
    output renamed_instr_t           rs_instr,
    output logic                     rs_prs1_rdy,
    output logic                     rs_prs2_rdy,

    // Writeback and recovery
    input  logic                     wb_valid,
    input  logic [PHYS_REG_BITS-1:0] wb_prd,
    input  logic                     mispredict
);

    // The ready table is indexed directly by physical register numbers.
    if (NUM_PHYS_REGS != 2 ** PHYS_REG_BITS) begin : g_phys_regs_check
        $error("NUM_PHYS_REGS must equal 2**PHYS_REG_BITS");
    end

    dispatch_entry_t            w_in_entry;
    dispatch_entry_t            w_head;
    logic                       w_head_valid;
    rs_tgt_t                    w_tgt;
    logic                       w_tgt_ready;
    logic                       w_rs_req;
    logic                       w_fire;
    logic [NUM_PHYS_REGS-1:0]   rdy_q;
    logic [NUM_PHYS_REGS-1:0]   rdy_d;

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    assign w_in_entry.ckpt_map     = in_ckpt_map;
    assign w_in_entry.ckpt_fl_ptr  = in_ckpt_fl_ptr;
    assign w_in_entry.ckpt_rob_tag = in_ckpt_rob_tag;
    assign w_in_entry.instr        = in_instr;

    dispatch_skid_buf #(
        .WIDTH ($bits(dispatch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_skid_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (mispredict),
        .push_i  (in_valid),
        .pop_i   (w_fire),
        .data_i  (w_in_entry),
        .ready_o (in_ready),
        .valid_o (w_head_valid),
        .data_o  (w_head)
    );

    // ------------------------------------------------------------------
    // Routing and handshake
    // ------------------------------------------------------------------
    assign w_tgt = route_fu(w_head.instr.fu_type);

    // Ready of whichever reservation station the head is bound for.
    always_comb begin
        w_tgt_ready = alu_rs_ready;
        case (w_tgt)
            TGT_LSU: w_tgt_ready = lsu_rs_ready;
            TGT_BR:  w_tgt_ready = br_rs_ready;
            default: w_tgt_ready = alu_rs_ready;
        endcase
    end

    // Each side's valid is qualified by the other side's ready, so the ROB
    // and the station only ever observe an accepted transfer together.
    assign w_fire    = w_head_valid && rob_ready && w_tgt_ready && !mispredict;
    assign rob_valid = w_head_valid && w_tgt_ready && !mispredict;
    assign w_rs_req  = w_head_valid && rob_ready && !mispredict;

    assign alu_rs_valid = w_rs_req && (w_tgt == TGT_ALU);
    assign lsu_rs_valid = w_rs_req && (w_tgt == TGT_LSU);
    assign br_rs_valid  = w_rs_req && (w_tgt == TGT_BR);

    // ------------------------------------------------------------------
    // Payload
    // ------------------------------------------------------------------
    assign rob_instr = w_head.instr;
    assign rs_instr  = w_head.instr;

    // Checkpoint fields are meaningless for non-branches; present zeros so
    // the ROB never latches stale map data.
    assign rob_ckpt_map     = w_head.instr.is_branch ? w_head.ckpt_map     : '0;
    assign rob_ckpt_fl_ptr  = w_head.instr.is_branch ? w_head.ckpt_fl_ptr  : '0;
    assign rob_ckpt_rob_tag = w_head.instr.is_branch ? w_head.ckpt_rob_tag : '0;

    // ------------------------------------------------------------------
    // Physical register ready table
    // ------------------------------------------------------------------
    // Clear on allocation, then set on writeback so a same-cycle writeback
    // to the same register wins; register 0 is permanently ready.
    always_comb begin
        rdy_d = rdy_q;
        if (w_fire && w_head.instr.reg_write && (w_head.instr.prd != '0)) begin
            rdy_d[w_head.instr.prd] = 1'b0;
        end
        if (wb_valid) begin
            rdy_d[wb_prd] = 1'b1;
        end
        rdy_d[0] = 1'b1;
    end

    // Ready table state; a flush leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= '1;
        end else begin
            rdy_q <= rdy_d;
        end
    end

    // Operand lookup with writeback bypass, covering heads stalled in the
    // buffer as well as ones dispatching this cycle.
    assign rs_prs1_rdy = rdy_q[w_head.instr.prs1] ||
                         (wb_valid && (wb_prd == w_head.instr.prs1));
    assign rs_prs2_rdy = rdy_q[w_head.instr.prs2] ||
                         (wb_valid && (wb_prd == w_head.instr.prs2));

endmodule

`default_nettype wire
